// File: rtl/vga_timing_pkg.sv
// Timing constants and helper functions for the VGA raster generator.
// Holds the default 640x480@60 Hz timing values, the line/frame total
// derivations and the sync window boundary functions shared by the
// timing generator.
package vga_timing_pkg;

  // Default 640x480@60 Hz horizontal timing, in pixels
  localparam int DEF_H_ACTIVE = 32'sd640;
  localparam int DEF_H_FRONT  = 32'sd16;
  localparam int DEF_H_SYNC   = 32'sd96;
  localparam int DEF_H_BACK   = 32'sd48;

  // Default 640x480@60 Hz vertical timing, in lines
  localparam int DEF_V_ACTIVE = 32'sd480;
  localparam int DEF_V_FRONT  = 32'sd10;
  localparam int DEF_V_SYNC   = 32'sd2;
  localparam int DEF_V_BACK   = 32'sd33;

  // Default pixel clock divider and sync polarity (active-low)
  localparam int DEF_CLK_DIV  = 32'sd2;
  localparam bit DEF_SYNC_POL = 1'b0;

  // Total positions along one axis (visible + porches + sync)
  function automatic int axis_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

  // First counter value inside the sync pulse
  function automatic int sync_first(input int active, input int front);
    return active + front;
  endfunction

  // Last counter value inside the sync pulse (inclusive)
  function automatic int sync_last(input int active, input int front,
                                   input int sync);
    return active + front + sync - 32'sd1;
  endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_clock_enable.sv
// Pixel clock enable: divides the system clock by CLK_DIV.
// Ports:
//   clock - system clock
//   reset - asynchronous, active-high; clears the divider to 0
//   tick  - high for the one system clock in which the divider sits at
//           CLK_DIV-1; constantly high when CLK_DIV is 1
module pixel_clock_enable #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  // With CLK_DIV=1 the counter degenerates to a single bit that stays at 0
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_count_r;

  // Tick is a pure decode of the divider register, so it is glitch-free
  assign tick = (div_count_r == DIV_LAST);

  // Divider counter: 0..CLK_DIV-1, wrapping on the tick
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_count_r <= '0;
    end else if (tick) begin
      div_count_r <= '0;
    end else begin
      div_count_r <= div_count_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (640x480@60 Hz by default).
// Ports:
//   clock      - system clock
//   reset      - asynchronous, active-high
//   xAddr      - horizontal position, 0..H_TOTAL-1
//   yAddr      - vertical position, 0..V_TOTAL-1
//   inDisplay  - high while the position is inside the visible area
//   hsync      - horizontal sync, asserted level SYNC_POL
//   vsync      - vertical sync, asserted level SYNC_POL
//   pixelTick  - one-clock pulse in the first clock of each new position
//   frameStart - one-clock pulse in the first clock of position (0,0)
// All outputs come straight from registers loaded with the next counter
// values, so position, qualifier and syncs change on the same clock edge.
// Consumers that register colour one clock after xAddr must delay the
// syncs themselves.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic       clock,
  input  logic       reset,
  output logic [9:0] xAddr,
  output logic [9:0] yAddr,
  output logic       inDisplay,
  output logic       hsync,
  output logic       vsync,
  output logic       pixelTick,
  output logic       frameStart
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(sync_first(H_ACTIVE, H_FRONT));
  localparam logic [9:0] HS_LAST  = 10'(sync_last(H_ACTIVE, H_FRONT, H_SYNC));
  localparam logic [9:0] VS_FIRST = 10'(sync_first(V_ACTIVE, V_FRONT));
  localparam logic [9:0] VS_LAST  = 10'(sync_last(V_ACTIVE, V_FRONT, V_SYNC));

  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = ~SYNC_POL;

  logic       tick_s;
  logic [9:0] h_count_r;
  logic [9:0] v_count_r;
  logic [9:0] h_next_s;
  logic [9:0] v_next_s;
  logic       in_display_next_s;
  logic       hsync_next_s;
  logic       vsync_next_s;
  logic       frame_start_next_s;
  logic       in_display_r;
  logic       hsync_r;
  logic       vsync_r;
  logic       pixel_tick_r;
  logic       frame_start_r;

  pixel_clock_enable #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_clock_enable (
    .clock (clock),
    .reset (reset),
    .tick  (tick_s)
  );

  // Next raster position: advance on tick, wrapping both axes together
  always_comb begin
    h_next_s = h_count_r;
    v_next_s = v_count_r;
    if (tick_s) begin
      if (h_count_r == H_LAST) begin
        h_next_s = 10'd0;
        if (v_count_r == V_LAST) begin
          v_next_s = 10'd0;
        end else begin
          v_next_s = v_count_r + 10'd1;
        end
      end else begin
        h_next_s = h_count_r + 10'd1;
      end
    end else begin
      h_next_s = h_count_r;
      v_next_s = v_count_r;
    end
  end

  // Output decode from the next position; vsync only moves when the line
  // wraps because v_next_s only changes then
  always_comb begin
    in_display_next_s  = (h_next_s < H_VIS) && (v_next_s < V_VIS);
    hsync_next_s       = SYNC_OFF;
    vsync_next_s       = SYNC_OFF;
    frame_start_next_s = tick_s && (h_next_s == 10'd0) && (v_next_s == 10'd0);
    if ((h_next_s >= HS_FIRST) && (h_next_s <= HS_LAST)) begin
      hsync_next_s = SYNC_ON;
    end else begin
      hsync_next_s = SYNC_OFF;
    end
    if ((v_next_s >= VS_FIRST) && (v_next_s <= VS_LAST)) begin
      vsync_next_s = SYNC_ON;
    end else begin
      vsync_next_s = SYNC_OFF;
    end
  end

  // Counter and output registers; reset parks at the last position so the
  // first tick lands on (0,0) and raises frameStart
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_count_r     <= H_LAST;
      v_count_r     <= V_LAST;
      in_display_r  <= 1'b0;
      hsync_r       <= SYNC_OFF;
      vsync_r       <= SYNC_OFF;
      pixel_tick_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      h_count_r     <= h_next_s;
      v_count_r     <= v_next_s;
      in_display_r  <= in_display_next_s;
      hsync_r       <= hsync_next_s;
      vsync_r       <= vsync_next_s;
      pixel_tick_r  <= tick_s;
      frame_start_r <= frame_start_next_s;
    end
  end

  assign xAddr      = h_count_r;
  assign yAddr      = v_count_r;
  assign inDisplay  = in_display_r;
  assign hsync      = hsync_r;
  assign vsync      = vsync_r;
  assign pixelTick  = pixel_tick_r;
  assign frameStart = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced raster
// (15 x 10 positions) so whole frames fit in a short run.
// Instance a: CLK_DIV=3, active-low syncs. Instance b: CLK_DIV=1, active-high.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;  // 15
  localparam int VT = VA + VF + VS + VB;  // 10
  localparam int DIV_A = 3;
  localparam int DIV_B = 1;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       ind;
    logic       hs;
    logic       vs;
    logic       pt;
    logic       fs;
  } out_t;

  typedef struct {
    int   cyc;
    out_t exp;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] xa, ya, xb, yb;
  logic       ida, hsa, vsa, pta, fsa;
  logic       idb, hsb, vsb, ptb, fsb;
  int         cyc;
  int         checks = 0;
  int         failures = 0;

  vga_timing_gen #(
    .CLK_DIV(DIV_A), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b0)
  ) dut_a (
    .clock(clock), .reset(reset), .xAddr(xa), .yAddr(ya), .inDisplay(ida),
    .hsync(hsa), .vsync(vsa), .pixelTick(pta), .frameStart(fsa)
  );

  vga_timing_gen #(
    .CLK_DIV(DIV_B), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b1)
  ) dut_b (
    .clock(clock), .reset(reset), .xAddr(xb), .yAddr(yb), .inDisplay(idb),
    .hsync(hsb), .vsync(vsb), .pixelTick(ptb), .frameStart(fsb)
  );

  always #5 clock = ~clock;

  // Clock edges seen since reset was last released
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Reference: after c edges, k = c/div pixel ticks have occurred; tick k
  // lands on linear position (k-1) mod frame size.
  function automatic out_t model(input int c, input int div, input bit pol,
                                 input bit rst);
    out_t o;
    int   k, lin;
    o.x = 10'(HT - 1); o.y = 10'(VT - 1);
    o.ind = 1'b0; o.hs = ~pol; o.vs = ~pol; o.pt = 1'b0; o.fs = 1'b0;
    if (!rst) begin
      k = c / div;
      if (k > 0) begin
        lin   = (k - 1) % (HT * VT);
        o.x   = 10'(lin % HT);
        o.y   = 10'(lin / HT);
        o.ind = (lin % HT < HA) && (lin / HT < VA);
        o.hs  = (lin % HT >= HA + HF && lin % HT < HA + HF + HS) ? pol : ~pol;
        o.vs  = (lin / HT >= VA + VF && lin / HT < VA + VF + VS) ? pol : ~pol;
        o.pt  = (c % div == 0);
        o.fs  = o.pt && (lin == 0);
      end
    end
    return o;
  endfunction

  function automatic out_t got_a();
    return {xa, ya, ida, hsa, vsa, pta, fsa};
  endfunction

  function automatic out_t got_b();
    return {xb, yb, idb, hsb, vsb, ptb, fsb};
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got x=%0d y=%0d ind=%b hs=%b vs=%b pt=%b fs=%b exp x=%0d y=%0d ind=%b hs=%b vs=%b pt=%b fs=%b",
               name, cyc, got.x, got.y, got.ind, got.hs, got.vs, got.pt, got.fs,
               exp.x, exp.y, exp.ind, exp.hs, exp.vs, exp.pt, exp.fs);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Hold reset for two clocks and release it on a falling edge
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    int fs_a_first, fs_a_second, fs_b_first, fs_b_second;
    int ind_pos, hs_low, vs_low, pt_b_low, range_err;

    // Hand-derived vectors for instance a (div 3, active-low syncs)
    vecs.push_back('{0,   '{10'd14, 10'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}});
    vecs.push_back('{2,   '{10'd14, 10'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}});
    vecs.push_back('{3,   '{10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}});
    vecs.push_back('{4,   '{10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}});
    vecs.push_back('{6,   '{10'd1,  10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}});
    vecs.push_back('{24,  '{10'd7,  10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}});
    vecs.push_back('{27,  '{10'd8,  10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}});
    vecs.push_back('{33,  '{10'd10, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}});
    vecs.push_back('{39,  '{10'd12, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}});
    vecs.push_back('{42,  '{10'd13, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}});
    vecs.push_back('{48,  '{10'd0,  10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}});
    vecs.push_back('{318, '{10'd0,  10'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}});
    vecs.push_back('{363, '{10'd0,  10'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}});
    vecs.push_back('{408, '{10'd0,  10'd9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}});
    vecs.push_back('{450, '{10'd14, 10'd9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}});
    vecs.push_back('{453, '{10'd0,  10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}});

    do_reset();
    check("reset_b", got_b(), '{10'd14, 10'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    foreach (vecs[i]) begin
      while (cyc < vecs[i].cyc) begin
        @(negedge clock);
        #1;
      end
      check($sformatf("vec%0d", i), got_a(), vecs[i].exp);
    end

    // Mid-line reset at (5,3): linear 50, tick 51 at edge 153; hit mid-position
    do_reset();
    while (cyc < 154) begin
      @(negedge clock);
      #1;
    end
    check("pre_reset_a", got_a(), '{10'd5, 10'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    reset = 1'b1;
    #1;
    check("async_reset_a", got_a(), '{10'd14, 10'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    check("async_reset_b", got_b(), '{10'd14, 10'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("restart_a", got_a(), '{10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});

    // Frame-level measurements over edges 1..460
    do_reset();
    fs_a_first = -1; fs_a_second = -1; fs_b_first = -1; fs_b_second = -1;
    ind_pos = 0; hs_low = 0; vs_low = 0; pt_b_low = 0; range_err = 0;
    for (int n = 0; n < 460; n++) begin
      @(negedge clock);
      #1;
      if (fsa) begin
        if (fs_a_first < 0) fs_a_first = cyc;
        else if (fs_a_second < 0) fs_a_second = cyc;
      end
      if (fsb) begin
        if (fs_b_first < 0) fs_b_first = cyc;
        else if (fs_b_second < 0) fs_b_second = cyc;
      end
      if (cyc >= 3 && cyc < 453) begin
        if (pta && ida) ind_pos++;
        if (!hsa) hs_low++;
        if (!vsa) vs_low++;
      end
      if (!ptb) pt_b_low++;
      if (xa >= 10'(HT) || ya >= 10'(VT) || xb >= 10'(HT) || yb >= 10'(VT)) range_err++;
    end
    check_int("frame_period_a", fs_a_second - fs_a_first, HT * VT * DIV_A);
    check_int("frame_period_b", fs_b_second - fs_b_first, HT * VT * DIV_B);
    check_int("first_fs_a", fs_a_first, DIV_A);
    check_int("display_positions", ind_pos, HA * VA);
    check_int("hsync_low_clocks", hs_low, HS * VT * DIV_A);
    check_int("vsync_low_clocks", vs_low, VS * HT * DIV_A);
    check_int("pixel_tick_b_gaps", pt_b_low, 0);
    check_int("addr_range", range_err, 0);

    // Random reset activity, every clock compared against the model
    do_reset();
    for (int n = 0; n < 2500; n++) begin
      @(negedge clock);
      if (!reset && $urandom_range(0, 399) == 0) reset = 1'b1;
      else if (reset && $urandom_range(0, 2) == 0) reset = 1'b0;
      #1;
      check("rand_a", got_a(), model(cyc, DIV_A, 1'b0, reset));
      check("rand_b", got_b(), model(cyc, DIV_B, 1'b1, reset));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
